matmul_row_sequencer: RTL and testbench
=======================================

Name: matmul_row_sequencer

Overview:
- Sequential controller directly upstream of the parallel multiply-add set (lane op: result = a*b + c, PARALLEL_NUM lanes, 16 bits each, one scalar a broadcast to all lanes).
- Accepts a stream of K (scalar A element, B row) pairs. For each pair it drives the MAC set with the running accumulator row as c, then registers the returned result.
- After K terms it presents one finished output row, C[i][*] = bias + sum over k of A[i][k]*B[k][*], on a valid/ready interface.

Parameters:
PARALLEL_NUM, 28, number of 16-bit lanes per row; must match the attached MAC set.
K_W, 8, width of the inner-dimension length field; max K = 2^K_W - 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  single-cycle pulse that begins a row job; sampled only in IDLE.
k_len  input  K_W  number of terms K for the job; latched on an accepted start.
bias_en  input  1  latched on start; 1 = accumulator starts at bias_row, 0 = starts at zero.
bias_row  input  PARALLEL_NUM*16  initial accumulator row; lane j in bits [j*16 +: 16]; latched on start.
in_valid  input  1  an input term is present.
in_ready  output  1  the block will accept the term this cycle.
in_a  input  16  scalar A[i][k].
in_b  input  PARALLEL_NUM*16  row B[k][*], lane j in bits [j*16 +: 16].
mac_a  output  16  to the MAC set's scalar a input.
mac_b  output  PARALLEL_NUM*16  to the MAC set's b vector input.
mac_c  output  PARALLEL_NUM*16  to the MAC set's addend vector input; always equals the accumulator register.
mac_result  input  PARALLEL_NUM*16  combinational a*b+c returned by the MAC set.
out_valid  output  1  out_row holds a finished row.
out_ready  input  1  downstream accepts the row.
out_row  output  PARALLEL_NUM*16  finished row; equals the accumulator register.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, acc=0, cnt=0, latched k_len=0.
  - out_valid=0, in_ready=0, busy=0; mac_a=0, mac_b=0; mac_c=out_row=0.
  - Reset asserted mid-job aborts the job immediately. No partial row is emitted.
- States and transitions:
  - IDLE: in_ready=0, out_valid=0.
    - On start=1 with k_len>0: latch k_len; set acc = bias_en ? bias_row : 0; cnt=0; go to ACCUM.
    - On start=1 with k_len=0: load acc the same way; go directly to OUT.
  - ACCUM: in_ready=1.
    - mac_a=in_a and mac_b=in_b, combinational pass-through.
    - On in_valid & in_ready: acc <= mac_result and cnt <= cnt+1.
    - If cnt equals latched k_len-1 at that handshake, go to OUT.
    - in_valid=0 cycles hold acc and cnt unchanged; gaps are allowed.
  - OUT: out_valid=1, in_ready=0.
    - out_row holds stable while out_ready=0.
    - On out_ready=1: go to IDLE and clear acc to 0 on that edge.
- Outside ACCUM, mac_a and mac_b are driven to 0.
- start is ignored in ACCUM and OUT. It is not queued.
- Latency:
  - out_valid rises on the clock edge that captures the K-th term's result. It is visible the cycle after the last input handshake.
  - For k_len=0, out_valid is high the cycle after start.
  - Minimum job time is K+1 cycles plus the output handshake.
- Arithmetic: unsigned, per lane, modulo 2^16. The MAC set truncates product+addend to 16 bits, and this block stores mac_result unmodified. No saturation, no overflow flag.
- Next job: start may be accepted in the cycle after the output handshake, since IDLE is entered on that edge. Back-to-back rows incur exactly one IDLE cycle.
- The accumulator is one register of PARALLEL_NUM*16 bits. No other datapath storage is used beyond the latched k_len and cnt.

Test Plan:
- Basic accumulate: PARALLEL_NUM=4, k_len=3, bias_en=0, in_a=2,3,1, every in_b lane j = j+1 -> out_row lanes = 6,12,18,24; out_valid is high the cycle after the 3rd handshake.
- Bias and wrap-around: bias_en=1, bias lanes=5, k_len=1, in_a=0x0100, in_b lanes=0x0100 -> out_row lanes = 0x0005 (product 0x10000 truncated).
- Zero length: start with k_len=0, bias_en=1, bias lanes=0xABCD -> out_valid=1 the next cycle, out_row=0xABCD per lane, mac_a=0.
- Flow control: k_len=4 with in_valid low for 2 cycles between terms, then out_ready held low for 5 cycles -> result unchanged by the gaps; out_row stable and in_ready=0 throughout the stall; IDLE one cycle after out_ready=1.
- Spurious start: start pulsed while in ACCUM with a different k_len -> ignored; the job completes with the original K.
- Reset mid-job: rst_n low after 2 of 4 terms -> all outputs 0 immediately; a new job after release computes a fresh result with no residue from the aborted job.

Source files
------------

// File: rtl/matmul_row_sequencer_if.sv
// matmul_row_sequencer_if
// Groups the job-control, input-term stream, MAC-set bus and output-row
// stream used by matmul_row_sequencer.
//   start/k_len/bias_en/bias_row : job request (sampled in IDLE)
//   in_valid/in_ready/in_a/in_b  : stream of (A scalar, B row) terms
//   mac_a/mac_b/mac_c/mac_result : connection to the parallel multiply-add set
//   out_valid/out_ready/out_row  : finished output row
//   busy                         : sequencer is not idle
// The slave modport is the sequencer's view; master is the surrounding system.
interface matmul_row_sequencer_if #(
  parameter int PARALLEL_NUM = 28,
  parameter int K_W          = 8
);
  localparam int W = PARALLEL_NUM * 16;

  logic           start;
  logic [K_W-1:0] k_len;
  logic           bias_en;
  logic [W-1:0]   bias_row;
  logic           in_valid;
  logic           in_ready;
  logic [15:0]    in_a;
  logic [W-1:0]   in_b;
  logic [15:0]    mac_a;
  logic [W-1:0]   mac_b;
  logic [W-1:0]   mac_c;
  logic [W-1:0]   mac_result;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_row;
  logic           busy;

  modport slave (
    input  start, k_len, bias_en, bias_row,
    input  in_valid, in_a, in_b,
    output in_ready,
    output mac_a, mac_b, mac_c,
    input  mac_result,
    output out_valid, out_row,
    input  out_ready,
    output busy
  );

  modport master (
    output start, k_len, bias_en, bias_row,
    output in_valid, in_a, in_b,
    input  in_ready,
    input  mac_a, mac_b, mac_c,
    output mac_result,
    input  out_valid, out_row,
    output out_ready,
    input  busy
  );
endinterface

// File: rtl/matmul_row_sequencer.sv
// matmul_row_sequencer
// Sequences K (A scalar, B row) terms through an external parallel
// multiply-add set, accumulating C[i][*] = bias + sum_k A[i][k]*B[k][*]
// in a single row register, then offers the finished row on a
// valid/ready output.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, aborts any job in progress
//   bus   : matmul_row_sequencer_if.slave (job request, input terms,
//           MAC-set connection, output row, busy)
module matmul_row_sequencer #(
  parameter int PARALLEL_NUM = 28,
  parameter int K_W          = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  matmul_row_sequencer_if.slave  bus
);
  localparam int W = PARALLEL_NUM * 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   acc;
  logic [K_W-1:0] cnt;
  logic [K_W-1:0] k_lat;
  logic           in_ready_r;
  logic           out_valid_r;
  logic           busy_r;

  // Control flags are registered alongside the state so they always
  // match it; in_ready_r is high exactly while the state is ACCUM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      k_lat       <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc   <= bus.bias_en ? bus.bias_row : '0;
            cnt   <= '0;
            k_lat <= bus.k_len;
            busy_r <= 1'b1;
            // A zero-length job has nothing to accumulate, so the
            // initial accumulator is already the answer.
            if (bus.k_len != '0) begin
              state      <= ACCUM;
              in_ready_r <= 1'b1;
            end else begin
              state       <= OUT;
              out_valid_r <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (bus.in_valid) begin
            acc <= bus.mac_result;
            cnt <= cnt + K_W'(1);
            if (cnt == k_lat - K_W'(1)) begin
              state       <= OUT;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end
          end
        end

        OUT: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            acc         <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          acc         <= '0;
          cnt         <= '0;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // The MAC set sees the live input term only while terms are being
  // accepted; elsewhere its a/b inputs are held at zero.
  assign bus.mac_a     = in_ready_r ? bus.in_a : 16'd0;
  assign bus.mac_b     = in_ready_r ? bus.in_b : '0;
  assign bus.mac_c     = acc;
  assign bus.out_row   = acc;
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_matmul_row_sequencer.sv
// tb_matmul_row_sequencer
// Drives directed row jobs into matmul_row_sequencer with a behavioural
// MAC set attached, and compares every output on every cycle against a
// job-level model (phase + expected accumulator lanes), plus literal row
// values for each directed job.
module tb_matmul_row_sequencer;
  localparam int P  = 4;
  localparam int KW = 8;
  localparam int W  = P * 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  matmul_row_sequencer_if #(.PARALLEL_NUM(P), .K_W(KW)) bus ();

  matmul_row_sequencer #(.PARALLEL_NUM(P), .K_W(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural MAC set: per lane a*b+c truncated to 16 bits.
  logic [W-1:0] mac_res;
  always_comb begin
    mac_res = '0;
    for (int j = 0; j < P; j++) begin
      mac_res[j*16 +: 16] = 16'(32'(bus.mac_a) * 32'(bus.mac_b[j*16 +: 16]) + 32'(bus.mac_c[j*16 +: 16]));
    end
  end
  assign bus.mac_result = mac_res;

  int checks   = 0;
  int failures = 0;

  // Model: 0 = idle, 1 = accumulating, 2 = row offered.
  int           phase;
  logic [15:0]  exp_lane [P];
  logic [15:0]  exp_mac_a;
  logic [W-1:0] exp_mac_b;
  bit           cmp_en;

  logic [15:0]  va [8];
  logic [W-1:0] vb [8];

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] packRow();
    logic [W-1:0] r;
    for (int j = 0; j < P; j++) r[j*16 +: 16] = exp_lane[j];
    return r;
  endfunction

  function automatic logic [W-1:0] rep(input logic [15:0] v);
    logic [W-1:0] r;
    for (int j = 0; j < P; j++) r[j*16 +: 16] = v;
    return r;
  endfunction

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("busy",      W'(bus.busy),      W'(phase != 0));
      checkOutput("in_ready",  W'(bus.in_ready),  W'(phase == 1));
      checkOutput("out_valid", W'(bus.out_valid), W'(phase == 2));
      checkOutput("mac_c",     bus.mac_c,         packRow());
      checkOutput("out_row",   bus.out_row,       packRow());
      checkOutput("mac_a",     W'(bus.mac_a),     (phase == 1) ? W'(exp_mac_a) : '0);
      checkOutput("mac_b",     bus.mac_b,         (phase == 1) ? exp_mac_b : '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveTerm(input logic [15:0] a, input logic [W-1:0] b, input logic v);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = v;
    exp_mac_a    = a;
    exp_mac_b    = b;
  endtask

  task automatic clearModel();
    phase = 0;
    for (int j = 0; j < P; j++) exp_lane[j] = 16'd0;
  endtask

  // Runs one row job from IDLE. Terms come from va/vb. gap = idle input
  // cycles before each term after the first; stall = cycles out_ready is
  // held low; spurious pulses start during term 1; abort_after resets the
  // block before that term index (-1 = never).
  task automatic applyStimulus(input int k, input bit ben, input logic [15:0] bias,
                               input int gap, input int stall, input bit spurious,
                               input int abort_after, input logic [W-1:0] lit,
                               input string name);
    bus.start    = 1'b1;
    bus.k_len    = KW'(k);
    bus.bias_en  = ben;
    bus.bias_row = rep(bias);
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < P; j++) exp_lane[j] = ben ? bias : 16'd0;
    phase = (k > 0) ? 1 : 2;
    if (k == 0) checkOutput({name, "_mac_a_zero"}, W'(bus.mac_a), '0);

    for (int t = 0; t < k; t++) begin
      if (abort_after == t) begin
        rst_n = 1'b0;
        driveTerm(16'd0, '0, 1'b0);
        clearModel();
        #1;
        checkOutput({name, "_rst_out_valid"}, W'(bus.out_valid), '0);
        checkOutput({name, "_rst_in_ready"},  W'(bus.in_ready),  '0);
        checkOutput({name, "_rst_busy"},      W'(bus.busy),      '0);
        checkOutput({name, "_rst_out_row"},   bus.out_row,       '0);
        tick();
        tick();
        rst_n = 1'b1;
        return;
      end
      if (t > 0) begin
        for (int g = 0; g < gap; g++) begin
          driveTerm(16'hDEAD, rep(16'hBEEF), 1'b0);
          tick();
        end
      end
      driveTerm(va[t], vb[t], 1'b1);
      if (spurious && t == 1) begin
        bus.start = 1'b1;
        bus.k_len = KW'(1);
      end
      tick();
      bus.start = 1'b0;
      for (int j = 0; j < P; j++)
        exp_lane[j] = 16'(32'(exp_lane[j]) + 32'(va[t]) * 32'(vb[t][j*16 +: 16]));
      driveTerm(16'd0, '0, 1'b0);
      if (t == k - 1) phase = 2;
    end

    checkOutput({name, "_out_valid_latency"}, W'(bus.out_valid), W'(1));
    checkOutput({name, "_row_literal"}, bus.out_row, lit);
    for (int s = 0; s < stall; s++) tick();
    checkOutput({name, "_row_after_stall"}, bus.out_row, lit);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    clearModel();
  endtask

  initial begin
    cmp_en       = 1'b0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.k_len    = '0;
    bus.bias_en  = 1'b0;
    bus.bias_row = '0;
    bus.out_ready = 1'b0;
    driveTerm(16'd0, '0, 1'b0);
    clearModel();
    #2;
    checkOutput("reset_out_valid", W'(bus.out_valid), '0);
    checkOutput("reset_busy",      W'(bus.busy),      '0);
    checkOutput("reset_out_row",   bus.out_row,       '0);
    cmp_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic accumulate: lanes = 6*(j+1).
    va[0] = 16'd2; va[1] = 16'd3; va[2] = 16'd1;
    for (int t = 0; t < 3; t++)
      for (int j = 0; j < P; j++) vb[t][j*16 +: 16] = 16'(j + 1);
    applyStimulus(3, 1'b0, 16'd0, 0, 0, 1'b0, -1,
                  {16'd24, 16'd18, 16'd12, 16'd6}, "basic");

    // Bias with 16-bit wrap of the product.
    va[0] = 16'h0100; vb[0] = rep(16'h0100);
    applyStimulus(1, 1'b1, 16'd5, 0, 1, 1'b0, -1, rep(16'h0005), "wrap");

    // Zero-length job emits the bias directly.
    applyStimulus(0, 1'b1, 16'hABCD, 0, 0, 1'b0, -1, rep(16'hABCD), "zero_len");

    // Flow control: gaps between terms and a long output stall.
    for (int t = 0; t < 4; t++) begin
      va[t] = 16'(t + 1);
      for (int j = 0; j < P; j++) vb[t][j*16 +: 16] = 16'(10 * (j + 1));
    end
    applyStimulus(4, 1'b0, 16'd0, 2, 5, 1'b0, -1,
                  {16'd400, 16'd300, 16'd200, 16'd100}, "flow");
    checkOutput("flow_idle_after", W'(bus.busy), '0);
    tick();

    // Spurious start during accumulation must not shorten the job.
    for (int t = 0; t < 4; t++) begin
      va[t] = 16'd1;
      for (int j = 0; j < P; j++) vb[t][j*16 +: 16] = 16'(j + 1);
    end
    applyStimulus(4, 1'b0, 16'd0, 0, 0, 1'b1, -1,
                  {16'd16, 16'd12, 16'd8, 16'd4}, "spurious");

    // Reset after two of four terms, then a fresh job.
    for (int t = 0; t < 4; t++) begin
      va[t] = 16'hFFFF;
      vb[t] = rep(16'h1234);
    end
    applyStimulus(4, 1'b1, 16'h7777, 0, 0, 1'b0, 2, '0, "abort");
    tick();
    va[0] = 16'd1; va[1] = 16'd1;
    vb[0] = rep(16'd3); vb[1] = rep(16'd3);
    applyStimulus(2, 1'b0, 16'd0, 0, 2, 1'b0, -1, rep(16'd6), "post_reset");

    tick();
    tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

endmodule
